// File: rtl/sap_pkg.sv
// ============================================================================
// Module      : sap_pkg
// Description : Shared operation encodings for the SAP accumulator family.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sap_pkg;

    localparam int c_OP_W = 3;

    typedef enum logic [c_OP_W-1:0] {
        OP_HOLD = 3'b000,
        OP_CLR  = 3'b001,
        OP_INC  = 3'b010,
        OP_DEC  = 3'b011,
        OP_SHL  = 3'b100,
        OP_SHR  = 3'b101,
        OP_ROL  = 3'b110,
        OP_ROR  = 3'b111
    } op_e;

endpackage

`default_nettype wire

// File: rtl/accumulator_lifo.sv
// ============================================================================
// Module      : accumulator_lifo
// Description : DEPTH-entry save/restore stack with sticky error detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module accumulator_lifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear_error,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_pop_ok,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_error
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SP_W-1:0] c_SP_FULL = SP_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [SP_W-1:0]  r_sp;
    logic             r_error;

    logic [SP_W-1:0]  w_sp_m1;
    logic             w_push_ok;
    logic             w_err;

    assign o_full    = (r_sp == c_SP_FULL);
    assign o_empty   = (r_sp == '0);
    assign w_sp_m1   = r_sp - SP_W'(1);
    assign w_push_ok = i_push & ~i_pop & ~o_full;
    assign o_pop_ok  = i_pop & ~i_push & ~o_empty;
    assign o_data    = r_mem[w_sp_m1[IDX_W-1:0]];

    // Conflict, overflow and underflow all collapse into one sticky flag.
    assign w_err = (i_push & i_pop) | (i_push & o_full) | (i_pop & o_empty);

    assign o_error = r_error;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp    <= '0;
            r_error <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_sp <= r_sp + SP_W'(1);
            end else if (o_pop_ok) begin
                r_sp <= w_sp_m1;
            end
            if (w_err) begin
                r_error <= 1'b1;
            end else if (i_clear_error) begin
                r_error <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push_ok) begin
            r_mem[r_sp[IDX_W-1:0]] <= i_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/accumulator_stack.sv
// ============================================================================
// Module      : accumulator_stack
// Description : Bus accumulator with in-place ALU ops, flags and context LIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module accumulator_stack
    import sap_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             Clock,
    input  logic             Reset,
    inout  wire  [WIDTH-1:0] data_bus,
    output logic [WIDTH-1:0] alu_output,
    input  logic             enable_input,
    input  logic             enable_output,
    input  logic [2:0]       op,
    input  logic             push,
    input  logic             pop,
    input  logic             clear_error,
    output logic             flag_zero,
    output logic             flag_sign,
    output logic             flag_carry,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_error
);

    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_carry_nxt;
    logic [WIDTH-1:0] w_lifo_top;
    logic             w_pop_ok;
    logic             w_push_g;
    logic             w_pop_g;

    // A bus load outranks any stack request in the same cycle.
    assign w_push_g = push & ~enable_input;
    assign w_pop_g  = pop  & ~enable_input;

    accumulator_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk           (Clock),
        .rst           (Reset),
        .i_push        (w_push_g),
        .i_pop         (w_pop_g),
        .i_clear_error (clear_error),
        .i_data        (r_acc),
        .o_data        (w_lifo_top),
        .o_pop_ok      (w_pop_ok),
        .o_full        (stack_full),
        .o_empty       (stack_empty),
        .o_error       (stack_error)
    );

    always_comb begin
        w_acc_nxt   = r_acc;
        w_carry_nxt = r_carry;
        if (enable_input) begin
            // With enable_output also set the bus already carries r_acc.
            if (!enable_output) begin
                w_acc_nxt = data_bus;
            end
        end else if (push || pop) begin
            if (w_pop_ok) begin
                w_acc_nxt = w_lifo_top;
            end
        end else begin
            case (op_e'(op))
                OP_HOLD: ;
                OP_CLR: begin
                    w_acc_nxt   = '0;
                    w_carry_nxt = 1'b0;
                end
                OP_INC: {w_carry_nxt, w_acc_nxt} = {1'b0, r_acc} + (WIDTH+1)'(1);
                OP_DEC: {w_carry_nxt, w_acc_nxt} = {1'b0, r_acc} - (WIDTH+1)'(1);
                OP_SHL: {w_carry_nxt, w_acc_nxt} = {r_acc, 1'b0};
                OP_SHR: {w_acc_nxt, w_carry_nxt} = {1'b0, r_acc};
                OP_ROL: {w_carry_nxt, w_acc_nxt} = {r_acc, r_carry};
                OP_ROR: {w_acc_nxt, w_carry_nxt} = {r_carry, r_acc};
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_acc   <= RESET_VALUE;
            r_carry <= 1'b0;
        end else begin
            r_acc   <= w_acc_nxt;
            r_carry <= w_carry_nxt;
        end
    end

    assign data_bus   = enable_output ? r_acc : {WIDTH{1'bz}};
    assign alu_output = r_acc;
    assign flag_zero  = (r_acc == '0);
    assign flag_sign  = r_acc[WIDTH-1];
    assign flag_carry = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_accumulator_stack.sv
// ============================================================================
// Module      : tb_accumulator_stack
// Description : Self-checking bench for accumulator_stack (8x4 and 12x1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accumulator_stack;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Instance A: WIDTH=8, DEPTH=4, RESET_VALUE=0
    logic       a_rst, a_ein, a_eout, a_push, a_pop, a_clr;
    logic [2:0] a_op;
    logic [7:0] a_drv;
    logic       a_drv_en;
    wire  [7:0] a_bus;
    logic [7:0] a_acc;
    logic       a_z, a_s, a_c, a_full, a_empty, a_err;
    assign a_bus = a_drv_en ? a_drv : 8'bz;

    accumulator_stack #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h00)) dut_a (
        .Clock(Clock), .Reset(a_rst), .data_bus(a_bus), .alu_output(a_acc),
        .enable_input(a_ein), .enable_output(a_eout), .op(a_op),
        .push(a_push), .pop(a_pop), .clear_error(a_clr),
        .flag_zero(a_z), .flag_sign(a_s), .flag_carry(a_c),
        .stack_full(a_full), .stack_empty(a_empty), .stack_error(a_err)
    );

    // Instance B: WIDTH=12, DEPTH=1, RESET_VALUE=0x5A5
    logic        b_rst, b_ein, b_eout, b_push, b_pop, b_clr;
    logic [2:0]  b_op;
    logic [11:0] b_drv;
    logic        b_drv_en;
    wire  [11:0] b_bus;
    logic [11:0] b_acc;
    logic        b_z, b_s, b_c, b_full, b_empty, b_err;
    assign b_bus = b_drv_en ? b_drv : 12'bz;

    accumulator_stack #(.WIDTH(12), .DEPTH(1), .RESET_VALUE(12'h5A5)) dut_b (
        .Clock(Clock), .Reset(b_rst), .data_bus(b_bus), .alu_output(b_acc),
        .enable_input(b_ein), .enable_output(b_eout), .op(b_op),
        .push(b_push), .pop(b_pop), .clear_error(b_clr),
        .flag_zero(b_z), .flag_sign(b_s), .flag_carry(b_c),
        .stack_full(b_full), .stack_empty(b_empty), .stack_error(b_err)
    );

    int n_vec  = 0;
    int n_miss = 0;
    logic [15:0] q_exp [$];
    logic [15:0] e;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_a();
        a_rst = 0; a_ein = 0; a_eout = 0; a_push = 0; a_pop = 0; a_clr = 0;
        a_op = 3'b000; a_drv_en = 0; a_drv = 8'h00;
    endtask

    task automatic idle_b();
        b_rst = 0; b_ein = 0; b_eout = 0; b_push = 0; b_pop = 0; b_clr = 0;
        b_op = 3'b000; b_drv_en = 0; b_drv = 12'h000;
    endtask

    // Applies one A-side cycle and checks alu_output against the scoreboard.
    task automatic cyc_a(input logic [7:0] exp_acc, input string nm);
        q_exp.push_back({8'h00, exp_acc});
        tick();
        e = q_exp.pop_front();
        n_vec++;
        if ({8'h00, a_acc} !== e) begin
            n_miss++; $display("FAIL %s acc: got %h want %h", nm, a_acc, e[7:0]);
        end
    endtask

    task automatic load_a(input logic [7:0] v);
        a_ein = 1; a_drv_en = 1; a_drv = v;
        cyc_a(v, "load");
        a_ein = 0; a_drv_en = 0;
    endtask

    task automatic test_reset();
        idle_a(); a_rst = 1;
        cyc_a(8'h00, "reset");
        a_rst = 0;
        n_vec++;
        if ({a_c, a_full, a_empty, a_err, a_z, a_s} !== 6'b001010) begin
            n_miss++; $display("FAIL reset_flags: got %b want %b",
                               {a_c, a_full, a_empty, a_err, a_z, a_s}, 6'b001010);
        end
    endtask

    task automatic test_bus();
        load_a(8'hA5);
        a_eout = 1; #1;
        n_vec++;
        if (a_bus !== 8'hA5) begin
            n_miss++; $display("FAIL bus_read: got %h want %h", a_bus, 8'hA5);
        end
        n_vec++;
        if ({a_s, a_z} !== 2'b10) begin
            n_miss++; $display("FAIL sign_zero: got %b want %b", {a_s, a_z}, 2'b10);
        end
        // enable_input with enable_output: bus carries acc, acc unchanged
        a_ein = 1;
        cyc_a(8'hA5, "ein_eout");
        a_ein = 0; a_eout = 0;
        // bus released: external driver must be seen without contention
        a_drv_en = 1; a_drv = 8'h3C; #1;
        n_vec++;
        if (a_bus !== 8'h3C) begin
            n_miss++; $display("FAIL bus_release: got %h want %h", a_bus, 8'h3C);
        end
        cyc_a(8'hA5, "no_load");
        a_drv_en = 0;
    endtask

    task automatic test_inc_dec_clr();
        load_a(8'hFF);
        a_op = 3'b010; cyc_a(8'h00, "inc_wrap");
        n_vec++;
        if ({a_c, a_z} !== 2'b11) begin
            n_miss++; $display("FAIL inc_flags: got %b want %b", {a_c, a_z}, 2'b11);
        end
        a_op = 3'b011; cyc_a(8'hFF, "dec_wrap");
        n_vec++;
        if (a_c !== 1'b1) begin
            n_miss++; $display("FAIL dec_borrow: got %b want %b", a_c, 1'b1);
        end
        a_op = 3'b010; cyc_a(8'h00, "inc_again");
        a_op = 3'b010; cyc_a(8'h01, "inc_plain");
        n_vec++;
        if (a_c !== 1'b0) begin
            n_miss++; $display("FAIL inc_nocarry: got %b want %b", a_c, 1'b0);
        end
        a_op = 3'b010; cyc_a(8'h02, "inc_2");
        a_op = 3'b001; cyc_a(8'h00, "clear");
        n_vec++;
        if (a_c !== 1'b0) begin
            n_miss++; $display("FAIL clear_carry: got %b want %b", a_c, 1'b0);
        end
        a_op = 3'b000;
    endtask

    task automatic test_rotate();
        load_a(8'h81);
        a_op = 3'b110; cyc_a(8'h02, "rol");
        n_vec++;
        if (a_c !== 1'b1) begin
            n_miss++; $display("FAIL rol_carry: got %b want %b", a_c, 1'b1);
        end
        a_op = 3'b111; cyc_a(8'h81, "ror");
        n_vec++;
        if (a_c !== 1'b0) begin
            n_miss++; $display("FAIL ror_carry: got %b want %b", a_c, 1'b0);
        end
        a_op = 3'b100; cyc_a(8'h02, "shl");
        n_vec++;
        if (a_c !== 1'b1) begin
            n_miss++; $display("FAIL shl_carry: got %b want %b", a_c, 1'b1);
        end
        load_a(8'h81);
        a_op = 3'b101; cyc_a(8'h40, "shr");
        n_vec++;
        if (a_c !== 1'b1) begin
            n_miss++; $display("FAIL shr_carry: got %b want %b", a_c, 1'b1);
        end
        a_op = 3'b000;
    endtask

    task automatic test_stack();
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            load_a(vals[i]);
            a_push = 1; a_op = 3'b010;   // op dropped while pushing
            cyc_a(vals[i], "push");
            a_push = 0; a_op = 3'b000;
        end
        n_vec++;
        if ({a_full, a_empty, a_err} !== 3'b100) begin
            n_miss++; $display("FAIL full: got %b want %b", {a_full, a_empty, a_err}, 3'b100);
        end
        a_push = 1; cyc_a(8'h44, "push_over");
        a_push = 0;
        n_vec++;
        if ({a_full, a_err} !== 2'b11) begin
            n_miss++; $display("FAIL overflow: got %b want %b", {a_full, a_err}, 2'b11);
        end
        load_a(8'h00);
        for (int i = 3; i >= 0; i--) begin
            a_pop = 1; cyc_a(vals[i], "pop");
        end
        a_pop = 0;
        n_vec++;
        if ({a_empty, a_err, a_c} !== 3'b111) begin
            n_miss++; $display("FAIL empty: got %b want %b", {a_empty, a_err, a_c}, 3'b111);
        end
        // underflow together with clear_error: the new error wins
        a_pop = 1; a_clr = 1; cyc_a(8'h11, "pop_under");
        a_pop = 0; a_clr = 0;
        n_vec++;
        if (a_err !== 1'b1) begin
            n_miss++; $display("FAIL err_wins: got %b want %b", a_err, 1'b1);
        end
        cyc_a(8'h11, "idle");
        n_vec++;
        if (a_err !== 1'b1) begin
            n_miss++; $display("FAIL err_sticky: got %b want %b", a_err, 1'b1);
        end
        a_clr = 1; cyc_a(8'h11, "clear_err");
        a_clr = 0;
        n_vec++;
        if (a_err !== 1'b0) begin
            n_miss++; $display("FAIL err_clear: got %b want %b", a_err, 1'b0);
        end
    endtask

    task automatic test_priority();
        a_ein = 1; a_drv_en = 1; a_drv = 8'h5A; a_op = 3'b010; a_push = 1;
        cyc_a(8'h5A, "ein_over_all");
        a_ein = 0; a_drv_en = 0; a_op = 3'b000; a_push = 0;
        n_vec++;
        if ({a_empty, a_c, a_err} !== 3'b110) begin
            n_miss++; $display("FAIL prio_side: got %b want %b", {a_empty, a_c, a_err}, 3'b110);
        end
        a_push = 1; a_pop = 1; cyc_a(8'h5A, "push_pop");
        a_push = 0; a_pop = 0;
        n_vec++;
        if ({a_empty, a_err} !== 2'b11) begin
            n_miss++; $display("FAIL conflict: got %b want %b", {a_empty, a_err}, 2'b11);
        end
    endtask

    task automatic test_reset_midseq();
        a_push = 1; cyc_a(8'h5A, "push1");
        load_a(8'h77);
        a_push = 1; cyc_a(8'h77, "push2");
        a_push = 0;
        a_rst = 1; a_pop = 1; cyc_a(8'h00, "reset_pop");
        a_rst = 0; a_pop = 0;
        n_vec++;
        if ({a_empty, a_err, a_c} !== 3'b100) begin
            n_miss++; $display("FAIL rst_mid: got %b want %b", {a_empty, a_err, a_c}, 3'b100);
        end
        a_pop = 1; cyc_a(8'h00, "pop_after_rst");
        a_pop = 0;
    endtask

    task automatic test_param();
        idle_b(); b_rst = 1; tick(); b_rst = 0;
        n_vec++;
        if ({b_acc, b_empty, b_full} !== {12'h5A5, 2'b10}) begin
            n_miss++; $display("FAIL b_reset: got %h/%b%b want 5a5/10", b_acc, b_empty, b_full);
        end
        b_push = 1; tick(); b_push = 0;
        b_op = 3'b010; tick(); b_op = 3'b000;
        n_vec++;
        if ({b_acc, b_full} !== {12'h5A6, 1'b1}) begin
            n_miss++; $display("FAIL b_push_inc: got %h/%b want 5a6/1", b_acc, b_full);
        end
        b_push = 1; tick(); b_push = 0;
        b_pop = 1; tick(); b_pop = 0;
        n_vec++;
        if ({b_acc, b_empty, b_err} !== {12'h5A5, 2'b11}) begin
            n_miss++; $display("FAIL b_pop: got %h/%b%b want 5a5/11", b_acc, b_empty, b_err);
        end
        b_ein = 1; b_drv_en = 1; b_drv = 12'hFFF; tick(); b_ein = 0; b_drv_en = 0;
        b_op = 3'b010; tick(); b_op = 3'b000;
        n_vec++;
        if ({b_acc, b_c, b_z} !== {12'h000, 2'b11}) begin
            n_miss++; $display("FAIL b_wrap: got %h/%b%b want 000/11", b_acc, b_c, b_z);
        end
        b_push = 1; tick(); b_push = 0;
        b_rst = 1; b_pop = 1; tick(); b_rst = 0; b_pop = 0;
        n_vec++;
        if ({b_acc, b_empty, b_err, b_c} !== {12'h5A5, 3'b100}) begin
            n_miss++; $display("FAIL b_rst_mid: got %h/%b%b%b want 5a5/100",
                               b_acc, b_empty, b_err, b_c);
        end
    endtask

    initial begin
        idle_a(); idle_b();
        a_rst = 1; b_rst = 1;
        tick();
        test_reset();
        test_bus();
        test_inc_dec_clr();
        test_rotate();
        test_stack();
        test_priority();
        test_reset_midseq();
        test_param();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/accumulator_stack.md
Name: accumulator_stack

Overview:
- Parametrised next-generation SAP accumulator register: WIDTH-bit accumulator on a shared tri-state data bus, with a permanent ALU tap.
- Adds in-place operations: clear, increment, decrement, shift and rotate-through-carry.
- Adds zero/sign/carry flags and a DEPTH-entry save/restore LIFO for subroutine and interrupt context.
- Sits between the data bus and the ALU A-input; driven by control-sequencer strobes.

Parameters:
- WIDTH, 8, accumulator, bus and stack entry width (>=2).
- DEPTH, 4, number of LIFO entries (>=1).
- RESET_VALUE, 0, accumulator value after Reset.

Ports:
- Clock  input  1  single system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- data_bus  inout  WIDTH  shared bus; driven only when enable_output=1, else high-Z.
- alu_output  output  WIDTH  continuous copy of the accumulator.
- enable_input  input  1  load accumulator from data_bus at the clock edge.
- enable_output  input  1  drive the accumulator onto data_bus (combinational).
- op  input  3  in-place operation select.
- push  input  1  save accumulator to the LIFO.
- pop  input  1  restore accumulator from the LIFO.
- clear_error  input  1  clear sticky stack_error.
- flag_zero  output  1  accumulator == 0 (combinational).
- flag_sign  output  1  accumulator MSB (combinational).
- flag_carry  output  1  registered carry/borrow.
- stack_full  output  1  LIFO count == DEPTH.
- stack_empty  output  1  LIFO count == 0.
- stack_error  output  1  sticky overflow/underflow/conflict indicator.

Behaviour:
- Reset (sync, highest priority):
  - acc=RESET_VALUE, flag_carry=0, sp=0, stack_error=0.
  - LIFO contents are don't-care.
  - Any op, push or pop in the same cycle is ignored.
  - Reset mid-sequence discards all saved entries.
- Per-cycle priority (one action only): Reset > enable_input > pop/push > op. Lower-priority requests in that cycle are dropped with no side effects.
- enable_input=1: acc <= data_bus; carry unchanged.
  - If enable_output is also 1, the bus carries acc, so acc is unchanged.
- Op encoding (1-cycle latency, result visible on alu_output the cycle after the edge):
  - 000 hold.
  - 001 clear: acc=0, carry=0.
  - 010 inc: {carry,acc}=acc+1; wraps all-ones->0 with carry=1.
  - 011 dec: acc=acc-1; carry=borrow; 0->all-ones with carry=1.
  - 100 shl: carry=acc[MSB], acc={acc[MSB-1:0],0}.
  - 101 shr (logical): carry=acc[0], acc={0,acc[MSB:1]}.
  - 110 rol through carry: {carry,acc}={acc,carry}.
  - 111 ror through carry: {acc,carry}={carry,acc}.
- push (pop=0):
  - Not full: stack[sp]<=acc, sp<=sp+1.
  - Full: no change, stack_error<=1.
- pop (push=0):
  - Not empty: acc<=stack[sp-1], sp<=sp-1; carry unchanged.
  - Empty: acc unchanged, stack_error<=1.
- push and pop together: conflict; no state change, stack_error<=1.
- stack_error:
  - Sticky until clear_error=1 or Reset.
  - If clear_error and a new error occur in the same cycle, the error wins (stays 1).
- Status timing:
  - stack_full/stack_empty are decoded from the registered sp; sp width is clog2(DEPTH+1).
  - flag_zero/flag_sign are combinational from acc, so they track acc with 0 extra latency.
- data_bus is never driven while enable_output=0, including during Reset.

Decomposition:
- Shared package/include sap_pkg: op encodings (OP_HOLD, OP_CLR, OP_INC, OP_DEC, OP_SHL, OP_SHR, OP_ROL, OP_ROR) and the 3-bit op width constant.
- One natural sub-module, accumulator_lifo:
  - Parametrised WIDTH/DEPTH.
  - Storage, sp, full/empty, and error-on-overflow/underflow detection.
- Top level holds acc, carry, op datapath, priority logic and bus tri-state.

Test Plan:
- Reset, then enable_input with bus=0xA5, then enable_output=1 -> alu_output=0xA5, bus reads 0xA5; bus=Z when enable_output=0; flag_sign=1, flag_zero=0.
- acc=0xFF, op=inc -> acc=0x00, carry=1, flag_zero=1; then op=dec -> acc=0xFF, carry=1; op=clear -> acc=0, carry=0.
- acc=0x81, carry=0: op=rol -> acc=0x02, carry=1; op=ror -> acc=0x81, carry=0; op=shr -> acc=0x40, carry=1.
- DEPTH=4: push 0x11,0x22,0x33,0x44 -> stack_full=1; fifth push -> stack_error=1, contents intact; four pops return 0x44,0x33,0x22,0x11; stack_empty=1; extra pop -> acc stays 0x11, error stays set until clear_error.
- Simultaneous enable_input (bus=0x5A) with op=inc and push -> acc=0x5A, sp unchanged, carry unchanged; push+pop together -> no change, stack_error=1.
- Two pushes, then Reset asserted with pop=1 -> acc=RESET_VALUE, sp=0, stack_empty=1, stack_error=0; repeat with WIDTH=12, DEPTH=1 to confirm parametrisation.
